// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch control
//               block: datapath width, reset PC, PC step and FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam int              XLEN             = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_INC           = 32'd4;
    localparam logic [XLEN-1:0] ALIGN_MASK       = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_KILL  = 2'd2
    } fetch_state_e;

    // Force a byte address onto a word boundary.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ALIGN_MASK;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl_if
// Description : Bundle of instruction-memory, decode-side and redirect
//               signals of the fetch controller. master = fetch_ctrl,
//               slave = memory / pipeline environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_ctrl_if;
    import fetch_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;
    logic            stall;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_pc4;
    logic [XLEN-1:0] if_inst;
    logic            misalign_trap;

    modport master (
        output imem_req, imem_addr, if_valid, if_pc, if_pc4, if_inst, misalign_trap,
        input  imem_ack, imem_rdata, stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_pc, if_pc4, if_inst, misalign_trap,
        output imem_ack, imem_rdata, stall, redirect, redirect_pc
    );

endinterface
`default_nettype wire

// File: rtl/fetch_pc.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc
// Description : Program counter register. Load (redirect) wins over
//               increment (accepted fetch); otherwise the value holds.
//               Exports pc and pc+4, both wrapping modulo 2^32.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  wire logic            clock,
    input  wire logic            reset,
    input  wire logic            load_i,
    input  wire logic [XLEN-1:0] load_val_i,
    input  wire logic            inc_i,
    output logic      [XLEN-1:0] pc_o,
    output logic      [XLEN-1:0] pc4_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    // Next PC selection: load beats increment beats hold.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = load_val_i;
        end else if (inc_i) begin
            pc_d = pc_q + PC_INC;
        end
    end

    // PC register, returns to RESET_PC immediately on reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o  = pc_q;
    assign pc4_o = pc_q + PC_INC;

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Instruction fetch controller. Issues word fetches from the PC,
//               fills a single IF/ID slot, honours decode stall and branch
//               redirects. A redirect that hits an unacknowledged request
//               parks in KILL until the old request completes, then fetches
//               the stored target.
//               Optional feature macro: FETCH_CTRL_ALIGN_CHECK_EN
//                 defined   - misaligned redirect raises sticky misalign_trap
//                             and parks the block in IDLE until reset.
//                 undefined - redirect_pc[1:0] ignored, misalign_trap = 0.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  wire logic    clock,
    input  wire logic    reset,
    fetch_ctrl_if.master bus
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] tgt_q, tgt_d;
    logic            if_valid_q, if_valid_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;
    logic [XLEN-1:0] if_pc4_q, if_pc4_d;
    logic [XLEN-1:0] if_inst_q, if_inst_d;
    logic            trap_q, trap_d;

    logic            pc_load;
    logic [XLEN-1:0] pc_load_val;
    logic            pc_inc;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;

    logic            req;
    logic            hs;
    logic            consume;
    logic [XLEN-1:0] redir_tgt;
    logic            misalign;

`ifdef FETCH_CTRL_ALIGN_CHECK_EN
    assign redir_tgt = bus.redirect_pc;
    assign misalign  = bus.redirect && (bus.redirect_pc[1:0] != 2'b00);
`else
    assign redir_tgt = align_pc(bus.redirect_pc);
    assign misalign  = 1'b0;
`endif

    fetch_pc #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clock      (clock),
        .reset      (reset),
        .load_i     (pc_load),
        .load_val_i (pc_load_val),
        .inc_i      (pc_inc),
        .pc_o       (pc),
        .pc4_o      (pc4)
    );

    // KILL keeps the abandoned request alive until memory answers it.
    assign req     = ((state_q == ST_FETCH) && (!if_valid_q || !bus.stall)) ||
                     (state_q == ST_KILL);
    assign hs      = req && bus.imem_ack;
    assign consume = if_valid_q && !bus.stall;

    // Next-state, slot and PC control; redirect and misalign override the rest.
    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        trap_d      = trap_q;
        if_valid_d  = if_valid_q && !consume;
        if_pc_d     = if_pc_q;
        if_pc4_d    = if_pc4_q;
        if_inst_d   = if_inst_q;
        pc_load     = 1'b0;
        pc_load_val = redir_tgt;
        pc_inc      = 1'b0;

        if (bus.redirect) begin
            if_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (!trap_q) begin
                    state_d = ST_FETCH;
                end
                if (bus.redirect) begin
                    pc_load = 1'b1;
                end
            end
            ST_FETCH: begin
                if (bus.redirect) begin
                    if (req && !bus.imem_ack) begin
                        state_d = ST_KILL;
                        tgt_d   = redir_tgt;
                    end else begin
                        pc_load = 1'b1;
                    end
                end else if (hs) begin
                    if_valid_d = 1'b1;
                    if_pc_d    = pc;
                    if_pc4_d   = pc4;
                    if_inst_d  = bus.imem_rdata;
                    pc_inc     = 1'b1;
                end
            end
            ST_KILL: begin
                if (bus.redirect) begin
                    tgt_d = redir_tgt;
                end
                if (bus.imem_ack) begin
                    state_d     = ST_FETCH;
                    pc_load     = 1'b1;
                    pc_load_val = bus.redirect ? redir_tgt : tgt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (misalign) begin
            state_d    = ST_IDLE;
            trap_d     = 1'b1;
            if_valid_d = 1'b0;
            pc_load    = 1'b0;
            pc_inc     = 1'b0;
        end
    end

    // State, slot, stored redirect target and sticky trap registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tgt_q      <= RESET_PC;
            trap_q     <= 1'b0;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_pc4_q   <= '0;
            if_inst_q  <= '0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            trap_q     <= trap_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_pc4_q   <= if_pc4_d;
            if_inst_q  <= if_inst_d;
        end
    end

    assign bus.imem_req      = req;
    assign bus.imem_addr     = pc;
    assign bus.if_valid      = if_valid_q;
    assign bus.if_pc         = if_pc_q;
    assign bus.if_pc4        = if_pc4_q;
    assign bus.if_inst       = if_inst_q;
    assign bus.misalign_trap = trap_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Testbench for fetch_ctrl. Directed cycle checks on two
//               instances (RESET_PC 0 and 0xFFFF_FFFC), then a randomized
//               phase with a memory responder, random stall/redirect and a
//               scoreboard of expected delivered PCs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;
    import fetch_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    fetch_ctrl_if busA ();
    fetch_ctrl_if busB ();

    fetch_ctrl #(.RESET_PC(32'h0000_0000)) dutA (.clock(clock), .reset(reset), .bus(busA));
    fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dutB (.clock(clock), .reset(reset), .bus(busB));

    int total = 0;
    int bad   = 0;

    int   ack_mode = 0;   // 0 zero-wait, 1 random latency, 2 manual
    logic ack_man  = 1'b0;

    logic [31:0] exp_q[$];
    logic [31:0] last_pc   = 32'h0;
    int          delivered = 0;
    bit          mon_en    = 1'b0;

    bit          p_pend = 1'b0;
    logic [31:0] p_addr;
    bit          p_hold = 1'b0;
    logic [31:0] p_pc;
    logic [31:0] p_inst;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req"},   busA.imem_req,      32'h0);
        chk({tag, "_addr"},  busA.imem_addr,     32'h0);
        chk({tag, "_valid"}, busA.if_valid,      32'h0);
        chk({tag, "_pc"},    busA.if_pc,         32'h0);
        chk({tag, "_pc4"},   busA.if_pc4,        32'h0);
        chk({tag, "_inst"},  busA.if_inst,       32'h0);
        chk({tag, "_trap"},  busA.misalign_trap, 32'h0);
    endtask

    // Memory responder for instance A.
    initial begin
        logic a;
        busA.imem_ack   = 1'b0;
        busA.imem_rdata = 32'h0;
        forever begin
            @(negedge clock);
            #1;
            case (ack_mode)
                0:       a = busA.imem_req;
                1:       a = busA.imem_req ? ($urandom % 3 == 0) : ($urandom % 4 == 0);
                default: a = ack_man;
            endcase
            busA.imem_ack   = a;
            busA.imem_rdata = (a && busA.imem_req) ? mem_f(busA.imem_addr) : $urandom;
        end
    end

    // Zero-wait memory for instance B.
    initial begin
        busB.imem_ack   = 1'b0;
        busB.imem_rdata = 32'h0;
        forever begin
            @(negedge clock);
            #1;
            busB.imem_ack   = busB.imem_req;
            busB.imem_rdata = mem_f(busB.imem_addr);
        end
    end

    // Scoreboard monitor: delivered-slot order, slot hold, request hold.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clock);
            #2;
            if (mon_en && !reset) begin
                if (p_pend) begin
                    chk("req_held",  busA.imem_req,  32'h1);
                    chk("addr_held", busA.imem_addr, p_addr);
                end
                if (p_hold) begin
                    chk("hold_valid", busA.if_valid, 32'h1);
                    chk("hold_pc",    busA.if_pc,    p_pc);
                    chk("hold_inst",  busA.if_inst,  p_inst);
                end
                if (busA.if_valid && !busA.stall && !busA.redirect) begin
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : last_pc + 32'd4;
                    chk("slot_pc",   busA.if_pc,   e);
                    chk("slot_pc4",  busA.if_pc4,  e + 32'd4);
                    chk("slot_inst", busA.if_inst, mem_f(e));
                    last_pc = e;
                    delivered++;
                end
                p_pend = busA.imem_req && !busA.imem_ack;
                p_addr = busA.imem_addr;
                p_hold = busA.if_valid && busA.stall && !busA.redirect;
                p_pc   = busA.if_pc;
                p_inst = busA.if_inst;
            end else begin
                p_pend = 1'b0;
                p_hold = 1'b0;
            end
        end
    end

    // Main stimulus.
    initial begin
        logic [31:0] tgt;
        busA.stall = 1'b0; busA.redirect = 1'b0; busA.redirect_pc = 32'h0;
        busB.stall = 1'b0; busB.redirect = 1'b0; busB.redirect_pc = 32'h0;

        repeat (2) @(negedge clock);
        #2;
        chk_reset_vals("rst");
        chk("rstB_addr", busB.imem_addr, 32'hFFFF_FFFC);

        // Release reset: one IDLE cycle, then zero-wait streaming.
        @(negedge clock); reset = 1'b0; #2;
        chk("idle_req", busA.imem_req, 32'h0);
        @(negedge clock); #2;
        chk("c0_addr", busA.imem_addr, 32'h0);
        chk("c0_req",  busA.imem_req,  32'h1);
        chk("c0B_addr", busB.imem_addr, 32'hFFFF_FFFC);
        @(negedge clock); #2;
        chk("c1_addr",  busA.imem_addr, 32'h4);
        chk("c1_pc",    busA.if_pc,     32'h0);
        chk("c1_pc4",   busA.if_pc4,    32'h4);
        chk("c1_valid", busA.if_valid,  32'h1);
        chk("c1_inst",  busA.if_inst,   mem_f(32'h0));
        chk("c1B_addr", busB.imem_addr, 32'h0);
        chk("c1B_pc",   busB.if_pc,     32'hFFFF_FFFC);
        chk("c1B_pc4",  busB.if_pc4,    32'h0);
        @(negedge clock); #2;
        chk("c2_addr",  busA.imem_addr, 32'h8);
        chk("c2_pc",    busA.if_pc,     32'h4);
        chk("c2_pc4",   busA.if_pc4,    32'h8);
        chk("c2_valid", busA.if_valid,  32'h1);

        // Stall three cycles on slot pc=8.
        for (int k = 0; k < 3; k++) begin
            @(negedge clock); busA.stall = 1'b1; #2;
            chk("stall_pc",    busA.if_pc,     32'h8);
            chk("stall_req",   busA.imem_req,  32'h0);
            chk("stall_addr",  busA.imem_addr, 32'hC);
            chk("stall_valid", busA.if_valid,  32'h1);
        end
        @(negedge clock); busA.stall = 1'b0; #2;
        chk("unstall_req", busA.imem_req, 32'h1);
        chk("unstall_pc",  busA.if_pc,    32'h8);
        @(negedge clock); #2;
        chk("resume_pc", busA.if_pc, 32'hC);

        // Delayed ack with redirect in the second waiting cycle.
        @(negedge clock); ack_mode = 2; ack_man = 1'b0; #2;
        chk("d0_addr", busA.imem_addr, 32'h14);
        chk("d0_pc",   busA.if_pc,     32'h10);
        @(negedge clock); busA.redirect = 1'b1; busA.redirect_pc = 32'h100; #2;
        @(negedge clock); busA.redirect = 1'b0; #2;
        chk("kill_req",   busA.imem_req,  32'h1);
        chk("kill_addr",  busA.imem_addr, 32'h14);
        chk("kill_valid", busA.if_valid,  32'h0);
        @(negedge clock); ack_man = 1'b1; #2;
        chk("kill_addr2", busA.imem_addr, 32'h14);
        @(negedge clock); ack_man = 1'b0; ack_mode = 0; #2;
        chk("post_kill_valid", busA.if_valid,  32'h0);
        chk("post_kill_addr",  busA.imem_addr, 32'h100);
        @(negedge clock); #2;
        chk("tgt_pc",   busA.if_pc,   32'h100);
        chk("tgt_inst", busA.if_inst, mem_f(32'h100));

        // Redirect to 0x40 coincident with ack and stall.
        @(negedge clock); busA.redirect = 1'b1; busA.redirect_pc = 32'h200; busA.stall = 1'b1; #2;
        @(negedge clock); busA.redirect_pc = 32'h40; #2;
        chk("coinc_req", busA.imem_req, 32'h1);
        @(negedge clock); busA.redirect = 1'b0; busA.stall = 1'b0; #2;
        chk("coinc_valid", busA.if_valid,  32'h0);
        chk("coinc_addr",  busA.imem_addr, 32'h40);

        // Misaligned redirect.
        @(negedge clock); busA.redirect = 1'b1; busA.redirect_pc = 32'h102; #2;
        chk("pre_mis_pc", busA.if_pc, 32'h40);
        @(negedge clock); busA.redirect = 1'b0; #2;
`ifdef FETCH_CTRL_ALIGN_CHECK_EN
        for (int k = 0; k < 3; k++) begin
            chk("mis_trap",  busA.misalign_trap, 32'h1);
            chk("mis_valid", busA.if_valid,      32'h0);
            chk("mis_req",   busA.imem_req,      32'h0);
            @(negedge clock); #2;
        end
`else
        chk("mis_trap",  busA.misalign_trap, 32'h0);
        chk("mis_addr",  busA.imem_addr,     32'h100);
        chk("mis_valid", busA.if_valid,      32'h0);
        @(negedge clock); #2;
        chk("mis_pc", busA.if_pc, 32'h100);
`endif

        // Reset asserted mid-cycle with a request outstanding.
        @(negedge clock); ack_mode = 2; ack_man = 1'b0;
        busA.redirect = 1'b1; busA.redirect_pc = 32'h300;
        @(negedge clock); busA.redirect = 1'b0;
        #3 reset = 1'b1; ack_man = 1'b1;
        #1 chk_reset_vals("async");
        repeat (2) @(negedge clock);
        reset = 1'b0; ack_man = 1'b0; ack_mode = 0;
        busA.redirect = 1'b1; busA.redirect_pc = 32'h80; #2;
        chk("idle_redir_req", busA.imem_req, 32'h0);
        @(negedge clock); busA.redirect = 1'b0; #2;
        chk("idle_redir_addr", busA.imem_addr, 32'h80);
        chk("idle_redir_trap", busA.misalign_trap, 32'h0);
        @(negedge clock); #2;
        chk("idle_redir_pc", busA.if_pc, 32'h80);

        // Randomized phase with scoreboard.
        @(negedge clock);
        reset = 1'b1;
        exp_q.delete();
        exp_q.push_back(32'h0);
        busA.stall = 1'b0; busA.redirect = 1'b0; ack_mode = 1;
        @(negedge clock);
        reset = 1'b0; last_pc = 32'h0; mon_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            busA.stall = ($urandom % 3 == 0);
            if ($urandom % 10 == 0) begin
                tgt = $urandom & 32'h0003_FFFF;
`ifdef FETCH_CTRL_ALIGN_CHECK_EN
                tgt = tgt & 32'hFFFF_FFFC;
`endif
                busA.redirect    = 1'b1;
                busA.redirect_pc = tgt;
                exp_q.delete();
                exp_q.push_back(tgt & 32'hFFFF_FFFC);
            end else begin
                busA.redirect = 1'b0;
            end
        end
        @(negedge clock);
        busA.redirect = 1'b0; busA.stall = 1'b0;
        #3 mon_en = 1'b0;
        chk("delivered_min", (delivered > 100) ? 32'h1 : 32'h0, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
